// File: rtl/muldiv_if.sv
// Request/response bundle between the control decoder and the HI/LO
// multiply/divide sequencer.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             hi_w;
  logic             lo_w;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi_w, lo_w, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi_w, lo_w, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply / restoring-divide sequencer feeding HI/LO.
// Optional MULDIV_EARLY_OUT_EN: mult exits once no multiplier bits remain; div by zero exits after one cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic               is_div, sign_a, sign_b;
  logic [WIDTH-1:0]   opnd;            // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_hi, acc_lo;  // product halves, or {remainder, quotient}
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [WIDTH-1:0]   hi_step, lo_step;
  logic               last_iter, early;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    a_abs = a_neg ? -bus.a : bus.a;
    b_abs = b_neg ? -bus.b : bus.b;
  end

  // One shift-add or restore step on the current accumulator.
  always_comb begin
    sum    = {1'b0, acc_hi} + {1'b0, opnd};
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        hi_step = diff[WIDTH-1:0];
        lo_step = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = rem_sh[WIDTH-1:0];
        lo_step = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else if (acc_lo[0]) begin
      hi_step = sum[WIDTH:1];
      lo_step = {sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      hi_step = {1'b0, acc_hi[WIDTH-1:1]};
      lo_step = {acc_hi[0], acc_lo[WIDTH-1:1]};
    end
  end

  assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] pending;

  // Low bits of lo_step not yet consumed are the untouched multiplier bits.
  always_comb begin
    shamt   = CW'(WIDTH - 1) - cnt;
    pending = lo_step & ({WIDTH{1'b1}} >> ({1'b0, cnt} + 1'b1));
    early   = is_div ? (opnd == '0) : (pending == '0);
  end
`else
  assign early = 1'b0;
`endif

  // Sign fix-up. A zero divisor leaves the all-ones quotient untouched while
  // the remainder fix restores the original dividend.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    quo_fix  = ((sign_a ^ sign_b) && (opnd != '0)) ? -acc_lo : acc_lo;
    rem_fix  = sign_a ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx is given its hold value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start && !bus.flush) state_nx = CALC;
      CALC:    if (bus.flush)                state_nx = IDLE;
               else if (last_iter || early)  state_nx = FIX;
      FIX:     state_nx = bus.flush ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy = (state == CALC) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.hi_w = (state == DONE);
  assign bus.lo_w = (state == DONE);

  // NOTE: registers use non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      is_div     <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      opnd       <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      bus.hi_out <= '0;
      bus.lo_out <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.flush) begin
          cnt    <= '0;
          is_div <= bus.op[1];
          sign_a <= a_neg;
          sign_b <= b_neg;
          acc_hi <= '0;
          opnd   <= bus.op[1] ? b_abs : a_abs;
          acc_lo <= bus.op[1] ? a_abs : b_abs;
        end
        CALC: begin
          cnt    <= cnt + 1'b1;
          acc_hi <= hi_step;
          acc_lo <= lo_step;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            if (is_div) begin
              acc_hi <= acc_lo;
              acc_lo <= '1;
            end else begin
              {acc_hi, acc_lo} <= {hi_step, lo_step} >> shamt;
            end
          end
`endif
        end
        FIX: if (!bus.flush) begin
          bus.hi_out <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          bus.lo_out <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-level behavioural model plus
// directed literal cases and randomized operations.
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {hi, lo} result straight from the arithmetic definition.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return ux * uy;
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          return {r[31:0], q[31:0]};
        end
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Cycles from start to done.
  function automatic int lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] mag;
    int          p;
    if (o[1]) return (y == 32'h0) ? 3 : W + 2;
    mag = (o == 2'b00 && y[31]) ? -y : y;
    if (mag == 32'h0) return 3;
    p = 0;
    for (int i = 0; i < W; i++) if (mag[i]) p = i;
    return p + 3;
`else
    if (o == 2'b11 && y === 32'hx) return 0;
    return W + 2;
`endif
  endfunction

  // Behavioural model: checked every cycle, then advanced with this cycle's inputs.
  bit          m_busy = 0, m_done = 0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(negedge clk) begin
    check("cycle", {bus.busy, bus.done, bus.hi_w, bus.lo_w, bus.hi_out, bus.lo_out},
                   {m_busy, m_done, m_done, m_done, m_hi, m_lo});
    if (rst) begin
      m_busy = 0; m_done = 0; m_hi = '0; m_lo = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (bus.flush) m_busy = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo;
        end
      end
    end else if (bus.start && !bus.flush) begin
      m_busy = 1;
      m_left = lat(bus.op, bus.b) - 1;
      {p_hi, p_lo} = ref_res(bus.op, bus.a, bus.b);
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el,
                       output int latency, output int nbusy);
    bit seen;
    int t0;
    seen = 0; nbusy = 0; latency = -1;
    bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < W + 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        seen = 1;
        latency = cyc - t0;
        check("res_hi", bus.hi_out, eh);
        check("res_lo", bus.lo_out, el);
        check("strobes", {bus.hi_w, bus.lo_w}, 2'b11);
      end
    end
    check("done_seen", seen, 1'b1);
    check("latency", latency, lat(o, y));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic rnd_op();
    int fa;
    fa = ($urandom_range(0, 5) == 0) ? $urandom_range(1, W + 3) : 0;
    bus.op = 2'($urandom_range(0, 3)); bus.a = pick(); bus.b = pick(); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= W + 4; k++) begin
      bus.flush = (k == fa);
      @(posedge clk); #1;
    end
    bus.flush = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lt, nb;
    bit  seen;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_zero", {bus.busy, bus.done, bus.hi_w, bus.lo_w, bus.hi_out, bus.lo_out}, '0);
    @(posedge clk); #1;

    // Pin the model with hand-computed values.
    check("pin_mult",  ref_res(2'b00, 32'hFFFF_FFFD, 32'h7), 64'hFFFF_FFFF_FFFF_FFEB);
    check("pin_divov", ref_res(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("pin_div0",  ref_res(2'b11, 32'h1234, 32'h0), 64'h0000_1234_FFFF_FFFF);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, lt, nb);
    check("multu_latency34", lt, 34);
    check("multu_busy33", nb, 33);
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, lt, nb);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, lt, nb);
    do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, lt, nb);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, lt, nb);
    do_op(2'b10, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, lt, nb);
    do_op(2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, lt, nb);

    // Flush mid-multiply with an ignored second start.
    bus.op = 2'b00; bus.a = 32'd123; bus.b = 32'd456; bus.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 10; i++) begin
      bus.start = (i == 5);
      bus.a     = 32'hDEAD;
      bus.flush = (i == 10);
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy_drop", bus.busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.hi_w || bus.lo_w) seen = 1;
    end
    check("flush_no_done", seen, 1'b0);
    check("flush_hold_hi", bus.hi_out, 32'h1234);
    check("flush_hold_lo", bus.lo_out, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // Flush and start together in idle.
    bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_wins", bus.busy, 1'b0);
    @(posedge clk); #1;

    // Reset mid-divide.
    bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_op", {bus.busy, bus.done, bus.hi_w, bus.lo_w, bus.hi_out, bus.lo_out}, '0);
    @(posedge clk); #1;

`ifdef MULDIV_EARLY_OUT_EN
    do_op(2'b01, 32'd5, 32'd1, 32'd0, 32'd5, lt, nb);
    check("early_latency3", lt, 3);
`endif

    for (int n = 0; n < 40; n++) rnd_op();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource of the 54-instruction MIPS CPU.
- Accepts a start pulse from the control decoder for mult, multu, div or divu.
- Runs an iterative radix-2 shift-add or restoring-divide datapath, and holds the CPU via busy until the result is ready.
- Issues single-cycle HI/LO write strobes with the results. Exception or eret flush can abort an operation in flight.

Parameters:
- WIDTH, 32: operand width. Must be even and at least 4. Also sets the iteration count.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- op  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu
- a  in  WIDTH  rs operand (multiplicand / dividend); captured with start
- b  in  WIDTH  rt operand (multiplier / divisor); captured with start
- flush  in  1  abort current operation, for exception or eret
- busy  out  1  high while an operation is in progress; drives the PC/RF stall
- done  out  1  one-cycle pulse; results valid in the same cycle
- hi_w  out  1  HI write strobe; equals done
- lo_w  out  1  LO write strobe; equals done
- hi_out  out  WIDTH  product high half or remainder
- lo_out  out  WIDTH  product low half or quotient

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; busy, done, hi_w, lo_w = 0; hi_out, lo_out = 0; iteration counter = 0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches a, b and op.
  - Signed ops (00, 10) latch absolute values plus the sign flags a[MSB] and b[MSB].
  - Next state is CALC with counter=0 and busy=1 from the next cycle.
- CALC:
  - One iteration per cycle, counter 0..WIDTH-1. After iteration WIDTH-1, go to FIX.
  - Multiply iteration: if multiplier LSB is set, add multiplicand to the 2*WIDTH accumulator upper half with carry; shift right 1.
  - Divide iteration: shift {rem, quo} left 1; trial subtract divisor from rem; if no borrow, keep the difference and set the quo LSB.
- FIX:
  - Mult: negate the 2*WIDTH product when the sign flags differ.
  - Div: negate the quotient when the sign flags differ; negate the remainder when the dividend is negative.
  - Load hi_out and lo_out; go to DONE.
- DONE: done=hi_w=lo_w=1 for exactly one cycle. Next state is IDLE; busy drops in this same cycle.
- Latency:
  - start high in cycle N gives done high in cycle N+WIDTH+2.
  - busy is high from N+1 through N+WIDTH+1.
  - A new start is accepted in the cycle after DONE at the earliest.
- hi_out and lo_out hold their last value until the next FIX.
- start is ignored when not in IDLE, with no queueing.
- flush:
  - In CALC or FIX: return to IDLE next cycle; no done or strobes; hi_out and lo_out unchanged.
  - In DONE the strobes still fire, since the write has already committed.
  - flush and start together in IDLE: flush wins and start is ignored.
- rst overrides everything, including mid-operation.
- Divide by zero (b=0): runs the full iteration count. Result is lo_out = all ones and hi_out = a for both div and divu, with no sign fix applied.
- Signed overflow: div of 0x80000000 by 0xFFFFFFFF gives lo_out=0x80000000 and hi_out=0, following wrap-around.
- Arithmetic:
  - Accumulator carry is kept in a WIDTH+1 bit upper half.
  - Negation is two's complement modulo 2^WIDTH, or modulo 2^(2*WIDTH) for the product.
  - Absolute value of the most negative number is its unsigned magnitude.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined, mult/multu:
  - Leave CALC as soon as the remaining unshifted multiplier bits are all zero.
  - The accumulator is shifted right by the remaining count in one step.
  - Minimum latency: done in cycle N+3 for b=0.
- When defined, div/divu with b=0 skip CALC, go straight to FIX, and produce the divide-by-zero result with done in N+3.
- When undefined: fixed latency WIDTH+2 for every operation, and no early-out logic is synthesized.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF: hi_out=0xFFFFFFFE, lo_out=0x00000001; done exactly 34 cycles after start; busy high for 33 cycles.
- mult a=0xFFFFFFFD (-3) b=0x00000007: hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; hi_w and lo_w are single-cycle pulses coincident with done.
- div a=0xFFFFFFF9 (-7) b=0x00000002: lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. divu a=100 b=7: lo_out=14, hi_out=2.
- div a=0x80000000 b=0xFFFFFFFF: lo_out=0x80000000, hi_out=0. divu a=0x1234 b=0: lo_out=0xFFFFFFFF, hi_out=0x1234.
- start mult, then flush at cycle 10: no done or strobes; hi_out and lo_out keep their prior values; busy low next cycle. A second start pulsed mid-operation is ignored.
- rst asserted mid-divide: all outputs zero next cycle. With MULDIV_EARLY_OUT_EN, multu a=5 b=1 gives done at start+3 with lo_out=5.
